// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU-wide constants used by the write-back arbiter and its bench.
// Slice convention for packed requester buses:
//   req_addr: unit i occupies [REG_ADDR_W*i +: REG_ADDR_W]
//   req_data: unit i occupies [WIDTH*i +: WIDTH]
package cpu_pkg;
   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam int unsigned NREQ_MAX = 8;
   localparam int unsigned GNT_ID_W = 3;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the execution units (master) and the arbiter (slave).
interface regfile_wb_arbiter_if import cpu_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREQ  = 4
);
   logic                         hold;
   logic [NREQ-1:0]              req_valid;
   logic [NREQ-1:0]              req_ready;
   logic [NREQ*REG_ADDR_W-1:0]   req_addr;
   logic [NREQ*WIDTH-1:0]        req_data;
   logic                         rf_we;
   logic [REG_ADDR_W-1:0]        rf_wa;
   logic [WIDTH-1:0]             rf_wd;
   logic [GNT_ID_W-1:0]          gnt_id;

   modport master (
      output hold, req_valid, req_addr, req_data,
      input  req_ready, rf_we, rf_wa, rf_wd, gnt_id
   );

   modport slave (
      input  hold, req_valid, req_addr, req_data,
      output req_ready, rf_we, rf_wa, rf_wd, gnt_id
   );
endinterface

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Round-robin winner search: first valid index at or after ptr, wrapping.
// The valid vector is doubled so the wrap becomes a plain lowest-bit search
// above a mask that removes the entries below ptr.
module rr_pick #(
   parameter  int unsigned NREQ  = 4,
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [PTR_W-1:0] idx
);
   logic [2*NREQ-1:0] dbl;
   logic [2*NREQ-1:0] lo_mask;
   logic [2*NREQ-1:0] masked;
   logic              found;

   // Masked priority search over the doubled request vector.
   always_comb begin
      dbl     = {valid, valid};
      lo_mask = (2*NREQ)'((1 << ptr) - 1);
      masked  = dbl & ~lo_mask;
      gnt     = '0;
      idx     = '0;
      found   = 1'b0;
      for (int unsigned j = 0; j < 2*NREQ; j++) begin
         if (!found && masked[j]) begin
            found          = 1'b1;
            idx            = PTR_W'(j % NREQ);
            gnt[j % NREQ]  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant of one requester per
// cycle, registered we/wa/wd toward the single register-file write port.
module regfile_wb_arbiter import cpu_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREQ  = 4
) (
   input logic              clk,
   input logic              rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      pick_idx;
   logic [NREQ-1:0]       pick_gnt;
   logic                  grant;
   logic                  we_q;
   logic [REG_ADDR_W-1:0] sel_addr;
   logic [WIDTH-1:0]      sel_data;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .idx   (pick_idx)
   );

   // Handshake: rst dominates hold, hold dominates requests. The registered
   // enable is also masked by rst so a pending write never lands in the file.
   always_comb begin
      grant         = !rst && !bus.hold && (|bus.req_valid);
      bus.req_ready = grant ? pick_gnt : '0;
      sel_addr      = bus.req_addr[int'(pick_idx)*REG_ADDR_W +: REG_ADDR_W];
      sel_data      = bus.req_data[int'(pick_idx)*WIDTH +: WIDTH];
      bus.rf_we     = we_q & ~rst;
   end

   // Output stage and round-robin pointer update on each accepted transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         bus.rf_wa  <= '0;
         bus.rf_wd  <= '0;
         bus.gnt_id <= '0;
         ptr        <= '0;
      end else if (grant) begin
         we_q       <= (sel_addr != REG_ZERO);
         bus.rf_wa  <= sel_addr;
         bus.rf_wd  <= sel_data;
         bus.gnt_id <= GNT_ID_W'(pick_idx);
         ptr        <= (pick_idx == PTR_W'(NREQ-1)) ? '0 : pick_idx + PTR_W'(1);
      end else begin
         we_q       <= 1'b0;
      end
   end
endmodule
